// File: rtl/imem_pkg.sv
//------------------------------------------------------------------------------
// Module  : imem_pkg
// Brief   : Shared constants and response entry type for the fetch path.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam int          INSTR_W      = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic               err;
  } resp_entry_t;

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
//------------------------------------------------------------------------------
// Module  : resp_fifo
// Brief   : Synchronous FIFO with the head entry presented on the output.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);
  // Empty reads as zero so the consumer never sees stale storage.
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
//------------------------------------------------------------------------------
// Module  : imem_responder
// Brief   : Instruction-memory side of the fetch interface with credit-based
//           flow control, fixed read latency and a backdoor load port.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_responder
  import imem_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = INSTR_W,
  parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(RESET_VECTOR),
  parameter int                DEPTH      = 4096,
  parameter int                LATENCY    = 1,
  parameter int                RESP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int                IDX_W       = $clog2(DEPTH);
  localparam int                CNT_W       = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CREDITS     = CNT_W'(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_req_word;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_ld_word;
  logic              w_ld_err;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_acc;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W:0]   w_push_entry;
  logic              w_empty;
  logic [DATA_W:0]   w_head;
  logic              r_run;
  logic [CNT_W-1:0]  r_outstanding;

  // Below-base is tested directly so a wrapped subtraction cannot alias in range.
  assign w_req_word = (req_addr - BASE) >> 2;
  assign w_req_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE) ||
                      (w_req_word >= DEPTH_WORDS);
  assign w_ld_word  = (ld_addr - BASE) >> 2;
  assign w_ld_err   = (ld_addr[1:0] != 2'b00) || (ld_addr < BASE) ||
                      (w_ld_word >= DEPTH_WORDS);

  assign w_rd_data  = w_req_err ? '0 : r_mem[w_req_word[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (ld_en && !w_ld_err) begin
      r_mem[w_ld_word[IDX_W-1:0]] <= ld_data;
    end
  end

  // Credits cover both pipeline and FIFO, so the FIFO can never overflow.
  assign req_ready = r_run && !ld_en && (r_outstanding < CREDITS);
  assign w_acc     = req_valid && req_ready;
  assign w_pop     = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run         <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= r_outstanding + CNT_W'(w_acc) - CNT_W'(w_pop);
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign w_push       = w_acc;
    assign w_push_entry = {w_rd_data, w_req_err};
  end else begin : g_pipe
    logic [LATENCY-2:0]           r_vld;
    logic [LATENCY-2:0][DATA_W:0] r_ent;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_vld <= '0;
        r_ent <= '0;
      end else begin
        r_vld[0] <= w_acc;
        r_ent[0] <= {w_rd_data, w_req_err};
        for (int i = 1; i < LATENCY - 1; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_ent[i] <= r_ent[i-1];
        end
      end
    end

    assign w_push       = r_vld[LATENCY-2];
    assign w_push_entry = r_ent[LATENCY-2];
  end

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty)
  );

  assign resp_valid = !w_empty;
  assign resp_data  = w_head[DATA_W:1];
  assign resp_err   = w_head[0];

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_imem_responder
// Brief   : Scoreboard bench for imem_responder (LATENCY=1 and LATENCY=3).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_responder;
  import imem_pkg::*;

  typedef struct {
    resp_entry_t e;
    int          acc;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        va = 1'b0, vb = 1'b0;
  logic [31:0] aa = '0, ab = '0;
  logic        ra, rb, rva, rvb;
  logic        rra = 1'b1, rrb = 1'b1;
  logic [31:0] da, db;
  logic        ea, eb;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t qa[$];
  exp_t qb[$];

  imem_responder dut_a (
    .clk(clk), .rst(rst),
    .req_valid(va), .req_ready(ra), .req_addr(aa),
    .resp_valid(rva), .resp_ready(rra), .resp_data(da), .resp_err(ea),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.LATENCY(3), .RESP_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(vb), .req_ready(rb), .req_addr(ab),
    .resp_valid(rvb), .resp_ready(rrb), .resp_data(db), .resp_err(eb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_resp(input bit sel, input logic [31:0] d, input logic e);
    exp_t x;
    bit   have;
    have = sel ? (qb.size() > 0) : (qa.size() > 0);
    if (!have) begin
      total++;
      bad++;
      $display("FAIL unexpected_resp dut%0d: got data=%h err=%b want none", sel, d, e);
    end else begin
      x = sel ? qb.pop_front() : qa.pop_front();
      chk(sel ? "resp_data_b" : "resp_data_a", d, x.e.data);
      chk(sel ? "resp_err_b" : "resp_err_a", {31'b0, e}, {31'b0, x.e.err});
      if (x.chk) chk(sel ? "latency_b" : "latency_a", cyc - x.acc, sel ? 3 : 1);
    end
  endtask

  always @(negedge clk) if (rva && rra) chk_resp(1'b0, da, ea);
  always @(negedge clk) if (rvb && rrb) chk_resp(1'b1, db, eb);

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit sel, input logic [31:0] addr, input logic [31:0] d,
                      input bit e, input bit lat_chk, input bit need_now);
    exp_t x;
    int   w;
    bit   done;
    w = 0;
    done = 1'b0;
    if (sel) begin vb = 1'b1; ab = addr; end
    else begin va = 1'b1; aa = addr; end
    while (!done && w < 40) begin
      @(negedge clk);
      if (sel ? rb : ra) begin
        x.e.data = d;
        x.e.err  = e;
        x.acc    = cyc;
        x.chk    = lat_chk;
        if (sel) qb.push_back(x);
        else qa.push_back(x);
        done = 1'b1;
      end else begin
        w++;
      end
      @(posedge clk);
      #1;
    end
    if (sel) vb = 1'b0;
    else va = 1'b0;
    total++;
    if (!done || (need_now && w != 0)) begin
      bad++;
      $display("FAIL accept dut%0d addr=%h: waited %0d cycles accepted=%0d want immediate=%0d",
               sel, addr, w, done, need_now);
    end
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    ld_en = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, ra}, 32'd0);
    chk("rst_resp_valid", {31'b0, rva}, 32'd0);
    chk("rst_resp_data", da, 32'd0);
    chk("rst_resp_err", {31'b0, ea}, 32'd0);
    chk("rst_resp_valid_b", {31'b0, rvb}, 32'd0);
    @(posedge clk);
    #1;
    load(32'h8000_0000, 32'h0000_0013);
    load(32'h8000_0004, 32'h0010_0093);
    load(32'h8000_0008, 32'h0020_0113);
    chk("rst_hold_req_ready", {31'b0, ra}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_cycle_req_ready", {31'b0, ra}, 32'd1);

    // back-to-back fetches
    send(0, 32'h8000_0000, 32'h0000_0013, 0, 1, 1);
    send(0, 32'h8000_0004, 32'h0010_0093, 0, 1, 1);
    send(0, 32'h8000_0008, 32'h0020_0113, 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: two credits, third request must stall
    rra = 1'b0;
    send(0, 32'h8000_0000, 32'h0000_0013, 0, 0, 1);
    send(0, 32'h8000_0004, 32'h0010_0093, 0, 0, 1);
    va = 1'b1;
    aa = 32'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'b0, ra}, 32'd0);
      chk("bp_resp_valid", {31'b0, rva}, 32'd1);
      chk("bp_head_held", da, 32'h0000_0013);
      @(posedge clk);
      #1;
    end
    rra = 1'b1;
    send(0, 32'h8000_0008, 32'h0020_0113, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;

    // error decode
    send(0, 32'h8000_0002, 32'h0, 1, 1, 1);
    send(0, 32'h7FFF_FFFC, 32'h0, 1, 1, 1);
    send(0, 32'h8000_4000, 32'h0, 1, 1, 1);
    send(0, 32'h8000_0004, 32'h0010_0093, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    // load interlock and ignored erroneous loads
    va = 1'b1;
    aa = 32'h8000_0000;
    ld_en = 1'b1;
    ld_addr = 32'h8000_0010;
    ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_blocks_req_ready", {31'b0, ra}, 32'd0);
    @(posedge clk);
    #1;
    va = 1'b0;
    ld_en = 1'b0;
    load(32'h8000_0012, 32'h1234_5678);
    load(32'h8000_4010, 32'h5555_AAAA);
    repeat (2) @(posedge clk);
    #1;
    send(0, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    // LATENCY=3 stream, no bubbles
    send(1, 32'h8000_0000, 32'h0000_0013, 0, 1, 1);
    send(1, 32'h8000_0004, 32'h0010_0093, 0, 1, 1);
    send(1, 32'h8000_0008, 32'h0020_0113, 0, 1, 1);
    send(1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 1);
    send(1, 32'h8000_0002, 32'h0, 1, 1, 1);
    send(1, 32'h8000_0004, 32'h0010_0093, 0, 1, 1);
    repeat (6) @(posedge clk);
    #1;

    // mid-run asynchronous reset with two outstanding
    rra = 1'b0;
    send(0, 32'h8000_0000, 32'h0000_0013, 0, 0, 1);
    send(0, 32'h8000_0004, 32'h0010_0093, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'b0, rva}, 32'd0);
    chk("midrst_req_ready", {31'b0, ra}, 32'd0);
    chk("midrst_resp_data", da, 32'd0);
    qa.delete();
    rra = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(0, 32'h8000_0008, 32'h0020_0113, 0, 1, 1);
    send(0, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 1);
    repeat (5) @(posedge clk);
    #1;

    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
